// File: rtl/spi_register_write_decoder.sv
// SPI mode-0 write-only front end: turns address + data frames into
// single-cycle register write strobes with an auto-incrementing address.
module spi_register_write_decoder #(
  parameter int AddressWidth = 8,
  parameter int BitWidth     = 8
) (
  input  logic                    CLK,
  input  logic                    _RST,
  input  logic                    SCK,
  input  logic                    MOSI,
  input  logic                    _CS,
  output logic [AddressWidth-1:0] AddressBus,
  output logic [BitWidth-1:0]     DataOut,
  output logic                    _HOLD,
  output logic                    FrameError
);

  localparam int SW = (AddressWidth > BitWidth) ? AddressWidth : BitWidth;
  localparam int CW = $clog2(SW + 1);
  localparam logic [CW-1:0] ADDR_LAST = CW'(AddressWidth - 1);
  localparam logic [CW-1:0] DATA_LAST = CW'(BitWidth - 1);

  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

  logic sck_meta, sck_sync, sck_prev;
  logic mosi_meta, mosi_sync;
  logic cs_meta, cs_sync, cs_prev;
  logic [1:0] fill;
  logic armed;

  // The _CS synchroniser resets to "released", so arming waits until the
  // pipeline has been refilled from the pin; a _CS held low through reset
  // therefore never arms.
  always_ff @(posedge CLK or negedge _RST) begin
    if (!_RST) begin
      sck_meta  <= 1'b0;
      sck_sync  <= 1'b0;
      sck_prev  <= 1'b0;
      mosi_meta <= 1'b0;
      mosi_sync <= 1'b0;
      cs_meta   <= 1'b1;
      cs_sync   <= 1'b1;
      cs_prev   <= 1'b1;
      fill      <= '0;
      armed     <= 1'b0;
    end else begin
      sck_meta  <= SCK;
      sck_sync  <= sck_meta;
      sck_prev  <= sck_sync;
      mosi_meta <= MOSI;
      mosi_sync <= mosi_meta;
      cs_meta   <= _CS;
      cs_sync   <= cs_meta;
      cs_prev   <= cs_sync;
      fill      <= {fill[0], 1'b1};
      if (fill[1] && cs_sync) armed <= 1'b1;
    end
  end

  logic sck_rise, cs_fall, cs_rise;
  assign sck_rise = sck_sync & ~sck_prev;
  assign cs_fall  = ~cs_sync & cs_prev;
  assign cs_rise  = cs_sync & ~cs_prev;

  state_t                  state_q, state_n;
  logic [CW-1:0]           cnt_q, cnt_n;
  logic [SW-1:0]           shift_q, shift_n, shifted;
  logic [AddressWidth-1:0] ptr_q, ptr_n, addr_n;
  logic [BitWidth-1:0]     data_n;
  logic                    hold_n, ferr_n;

  assign shifted = {shift_q[SW-2:0], mosi_sync};

  always_ff @(posedge CLK or negedge _RST) begin
    if (!_RST) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      shift_q    <= '0;
      ptr_q      <= '0;
      AddressBus <= '0;
      DataOut    <= '0;
      _HOLD      <= 1'b1;
      FrameError <= 1'b0;
    end else begin
      state_q    <= state_n;
      cnt_q      <= cnt_n;
      shift_q    <= shift_n;
      ptr_q      <= ptr_n;
      AddressBus <= addr_n;
      DataOut    <= data_n;
      _HOLD      <= hold_n;
      FrameError <= ferr_n;
    end
  end

  always_comb begin
    state_n = state_q;
    cnt_n   = cnt_q;
    shift_n = shift_q;
    ptr_n   = ptr_q;
    addr_n  = AddressBus;
    data_n  = DataOut;
    hold_n  = 1'b1;
    ferr_n  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (cs_fall && armed) begin
          state_n = ADDR;
          cnt_n   = '0;
          shift_n = '0;
        end
      end
      ADDR: begin
        if (sck_rise) begin
          shift_n = shifted;
          if (cnt_q == ADDR_LAST) begin
            ptr_n   = shifted[AddressWidth-1:0];
            cnt_n   = '0;
            state_n = DATA;
          end else begin
            cnt_n = cnt_q + 1'b1;
          end
        end
      end
      DATA: begin
        if (sck_rise) begin
          shift_n = shifted;
          if (cnt_q == DATA_LAST) begin
            addr_n = ptr_q;
            data_n = shifted[BitWidth-1:0];
            hold_n = 1'b0;
            ptr_n  = ptr_q + 1'b1;
            cnt_n  = '0;
          end else begin
            cnt_n = cnt_q + 1'b1;
          end
        end
      end
      default: state_n = IDLE;
    endcase

    // Checked against the post-shift count so a bit arriving with the
    // _CS rise still completes its field without flagging an error.
    if (cs_rise) begin
      state_n = IDLE;
      if (cnt_n != '0) ferr_n = 1'b1;
      cnt_n = '0;
    end
  end

endmodule

// File: tb/tb_spi_register_write_decoder.sv
// Scoreboard bench for spi_register_write_decoder: directed SPI frames push
// expected writes; a monitor pops them on every _HOLD strobe.
module tb_spi_register_write_decoder;

  logic       CLK = 1'b0;
  logic       _RST = 1'b0;
  logic       SCK = 1'b0;
  logic       MOSI = 1'b0;
  logic       _CS = 1'b1;
  logic [7:0] AddressBus;
  logic [7:0] DataOut;
  logic       _HOLD;
  logic       FrameError;

  spi_register_write_decoder #(.AddressWidth(8), .BitWidth(8)) dut (
    .CLK(CLK), ._RST(_RST), .SCK(SCK), .MOSI(MOSI), ._CS(_CS),
    .AddressBus(AddressBus), .DataOut(DataOut), ._HOLD(_HOLD),
    .FrameError(FrameError)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [7:0] addr;
    logic [7:0] data;
  } wr_t;

  wr_t sb[$];
  int  checks = 0;
  int  errors = 0;
  int  err_seen = 0;
  int  exp_err = 0;
  logic hold_prev = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge CLK) begin
    if (_RST) begin
      if (_HOLD === 1'b0) begin
        chk("hold_width", {31'd0, hold_prev}, 32'd0);
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, no write expected", AddressBus, DataOut);
        end else begin
          wr_t e;
          e = sb.pop_front();
          chk("wr_addr", {24'd0, AddressBus}, {24'd0, e.addr});
          chk("wr_data", {24'd0, DataOut}, {24'd0, e.data});
        end
      end
      hold_prev = (_HOLD === 1'b0);
      if (FrameError !== 1'b0) err_seen++;
    end
  end

  task automatic tick(input int unsigned n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic send_bits(input logic [7:0] v, input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      MOSI = v[7-i];
      tick(4);
      SCK = 1'b1;
      tick(4);
      SCK = 1'b0;
    end
  endtask

  task automatic expect_wr(input logic [7:0] a, input logic [7:0] d);
    wr_t e;
    e.addr = a;
    e.data = d;
    sb.push_back(e);
  endtask

  task automatic cs_low();
    _CS = 1'b0;
    tick(4);
  endtask

  task automatic cs_high();
    tick(4);
    _CS = 1'b1;
    tick(8);
  endtask

  initial begin
    // Reset
    tick(3);
    _RST = 1'b1;
    tick(6);
    @(negedge CLK);
    chk("rst_addr", {24'd0, AddressBus}, 32'h00);
    chk("rst_data", {24'd0, DataOut}, 32'h00);
    chk("rst_hold", {31'd0, _HOLD}, 32'd1);
    chk("rst_ferr", {31'd0, FrameError}, 32'd0);
    tick(2);

    // Single write, then outputs hold
    expect_wr(8'h12, 8'hA5);
    cs_low();
    send_bits(8'h12, 8);
    send_bits(8'hA5, 8);
    cs_high();
    @(negedge CLK);
    chk("hold_addr", {24'd0, AddressBus}, 32'h12);
    chk("hold_data", {24'd0, DataOut}, 32'hA5);
    chk("hold_idle", {31'd0, _HOLD}, 32'd1);
    tick(1);

    // Burst wrapping past 0xFF
    expect_wr(8'hFE, 8'h11);
    expect_wr(8'hFF, 8'h22);
    expect_wr(8'h00, 8'h33);
    cs_low();
    send_bits(8'hFE, 8);
    send_bits(8'h11, 8);
    send_bits(8'h22, 8);
    send_bits(8'h33, 8);
    cs_high();
    chk("burst_drained", sb.size(), 32'd0);

    // Partial data field, then address-only frame
    cs_low();
    send_bits(8'h40, 8);
    send_bits(8'hB8, 5);
    cs_high();
    exp_err++;
    chk("partial_ferr", err_seen, exp_err);
    cs_low();
    send_bits(8'h40, 8);
    cs_high();
    chk("addr_only_ferr", err_seen, exp_err);

    // Reset mid-frame with _CS kept low through release
    cs_low();
    send_bits(8'h20, 8);
    send_bits(8'h77, 4);
    _RST = 1'b0;
    tick(2);
    @(negedge CLK);
    chk("midrst_addr", {24'd0, AddressBus}, 32'h00);
    chk("midrst_data", {24'd0, DataOut}, 32'h00);
    tick(1);
    _RST = 1'b1;
    send_bits(8'h70, 4);
    send_bits(8'h55, 8);
    cs_high();
    chk("midrst_ferr", err_seen, exp_err);
    expect_wr(8'h21, 8'h99);
    cs_low();
    send_bits(8'h21, 8);
    send_bits(8'h99, 8);
    cs_high();
    chk("after_rst_drained", sb.size(), 32'd0);

    // Last SCK rise coincides with _CS rise
    expect_wr(8'h30, 8'h5C);
    cs_low();
    send_bits(8'h30, 8);
    send_bits(8'h5C, 7);
    MOSI = 1'b0;
    tick(4);
    SCK = 1'b1;
    _CS = 1'b1;
    tick(4);
    SCK = 1'b0;
    tick(8);
    chk("coincide_ferr", err_seen, exp_err);
    chk("coincide_drained", sb.size(), 32'd0);

    tick(4);
    chk("final_ferr", err_seen, exp_err);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
